// File: rtl/key_schedule_ctrl_if.sv
// Handshake and read-port bundle for the AES-128 key-schedule controller.
// The master drives requests and read indices; the slave returns round keys and status.
interface key_schedule_ctrl_if;
  logic         start;
  logic [0:127] key;
  logic [3:0]   rd_idx;
  logic [0:127] rd_key;
  logic         busy;
  logic         done;
  logic         key_valid;

  modport master (
    output start, key, rd_idx,
    input  rd_key, busy, done, key_valid
  );

  modport slave (
    input  start, key, rd_idx,
    output rd_key, busy, done, key_valid
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-expansion controller: one round key per cycle into an (NR+1)-slot store,
// with a registered read port and busy/done/key_valid status.
module key_schedule_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned NK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_schedule_ctrl_if.slave   bus
);

  localparam logic [3:0] NrIdx = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e       state_q;
  logic [3:0]   rnd_q;
  logic         busy_q;
  logic         done_q;
  logic         key_valid_q;
  logic [0:127] rd_key_q;
  logic [0:127] slot_q [NR+1];

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // w0 lives in bits [0:31]; each later word chains off the freshly updated previous word.
  function automatic logic [0:127] next_round_key(input logic [0:127] prev, input logic [3:0] r);
    logic [0:31]  w [NK];
    logic [0:31]  rot;
    logic [0:31]  t;
    logic [0:127] res;
    for (int i = 0; i < NK; i++) w[i] = prev[32*i +: 32];
    rot = {w[NK-1][8:31], w[NK-1][0:7]};
    t   = {SBOX[rot[0:7]], SBOX[rot[8:15]], SBOX[rot[16:23]], SBOX[rot[24:31]]}
          ^ {rcon(r), 24'h000000};
    w[0] = w[0] ^ t;
    for (int i = 1; i < NK; i++) w[i] = w[i] ^ w[i-1];
    res = '0;
    for (int i = 0; i < NK; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rnd_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      rd_key_q    <= '0;
      for (int i = 0; i <= NR; i++) slot_q[i] <= '0;
    end else begin
      // Non-blocking read sees pre-edge contents, so a same-slot write returns old data.
      rd_key_q <= (bus.rd_idx <= NrIdx) ? slot_q[bus.rd_idx] : '0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            slot_q[0]   <= bus.key;
            rnd_q       <= 4'd1;
            state_q     <= StExpand;
            busy_q      <= 1'b1;
            key_valid_q <= 1'b0;
          end
        end
        StExpand: begin
          slot_q[rnd_q] <= next_round_key(slot_q[rnd_q - 4'd1], rnd_q);
          if (rnd_q == NrIdx) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            key_valid_q <= 1'b1;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_key    = rd_key_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.key_valid = key_valid_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a word-level FIPS-197 key-expansion model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_key_schedule_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_ks [11];
  logic [127:0] a_ks   [11];

  key_schedule_ctrl_if bus ();

  key_schedule_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv = 8'h00;
      if (i != 0) begin
        inv = 8'h01;
        for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(i));
      end
      sbox_t[i] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int idx, output logic [127:0] v);
    bus.rd_idx = 4'(idx);
    step();
    v = bus.rd_key;
  endtask

  task automatic start_pulse(input logic [127:0] k);
    bus.key   = k;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Counts edges from the accepting edge (1) until done is seen; busy_n counts busy samples.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 1;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && lat < 40) begin
      step();
      lat++;
      if (bus.busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    logic [127:0] v;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.key = '0; bus.rd_idx = 4'd0;
    repeat (3) step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv: got %b expected 0", bus.key_valid); end
    rd(7, v);
    checks++; if (v !== '0) begin errors++; $display("FAIL reset_rdkey: got %h expected 0", v); end
  endtask

  task automatic test_fips();
    logic [127:0] v;
    int lat, bn;
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    rst_n = 1'b1;
    start_pulse(128'h2b7e151628aed2a6abf7158809cf4f3c);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fips_first_edge_busy: got %b expected 1", bus.busy); end
    wait_done(lat, bn);
    checks++; if (lat != 11) begin errors++; $display("FAIL fips_latency: got %0d expected 11", lat); end
    checks++; if (bus.key_valid !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL fips_status_at_done: got kv=%b busy=%b expected kv=1 busy=0", bus.key_valid, bus.busy); end
    rd(1, v);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL fips_done_pulse: got %b expected 0", bus.done); end
    checks++; if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++; $display("FAIL fips_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", v); end
    rd(10, v);
    checks++; if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL fips_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", v); end
    rd(0, v);
    checks++; if (v !== exp_ks[0]) begin errors++; $display("FAIL fips_rk0: got %h expected %h", v, exp_ks[0]); end
    for (int r = 2; r < 10; r++) begin
      rd(r, v);
      checks++; if (v !== exp_ks[r]) begin errors++; $display("FAIL fips_rk%0d: got %h expected %h", r, v, exp_ks[r]); end
    end
    checks++; if (bus.key_valid !== 1'b1) begin errors++; $display("FAIL fips_kv_hold: got %b expected 1", bus.key_valid); end
  endtask

  task automatic test_zero_key();
    logic [127:0] v;
    int lat, bn;
    start_pulse('0);
    wait_done(lat, bn);
    checks++; if (lat != 11) begin errors++; $display("FAIL zero_latency: got %0d expected 11", lat); end
    checks++; if (bn != 10) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 10", bn); end
    rd(1, v);
    checks++; if (v !== 128'h62636363626363636263636362636363) begin
      errors++; $display("FAIL zero_rk1: got %h expected 62636363626363636263636362636363", v); end
    rd(10, v);
    checks++; if (v !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      errors++; $display("FAIL zero_rk10: got %h expected b4ef5bcb3e92e21123e951cf6f8f188e", v); end
  endtask

  task automatic test_random();
    logic [127:0] k, v;
    int lat, bn;
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      start_pulse(k);
      wait_done(lat, bn);
      checks++; if (lat != 11) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 11", n, lat); end
      for (int r = 0; r < 11; r++) begin
        rd(r, v);
        checks++; if (v !== exp_ks[r]) begin errors++; $display("FAIL rand%0d_rk%0d: got %h expected %h", n, r, v, exp_ks[r]); end
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [127:0] ka, kb, v;
    int dn = 0;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    model_expand(ka);
    start_pulse(ka);
    repeat (3) step();
    bus.key = kb; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.key = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.done) dn++;
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", dn); end
    checks++; if (bus.key_valid !== 1'b1) begin errors++; $display("FAIL ignore_kv: got %b expected 1", bus.key_valid); end
    for (int r = 0; r < 11; r++) begin
      rd(r, v);
      checks++; if (v !== exp_ks[r]) begin errors++; $display("FAIL ignore_rk%0d: got %h expected %h", r, v, exp_ks[r]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k, v;
    int lat, bn, dn = 0;
    k = {$urandom, $urandom, $urandom, $urandom};
    start_pulse(k);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_status: got busy=%b done=%b kv=%b expected 0 0 0", bus.busy, bus.done, bus.key_valid); end
    rst_n = 1'b1;
    for (int r = 0; r < 16; r++) begin
      rd(r, v);
      if (bus.done) dn++;
      checks++; if (v !== '0) begin errors++; $display("FAIL midreset_rk%0d: got %h expected 0", r, v); end
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", dn); end
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    start_pulse(k);
    wait_done(lat, bn);
    checks++; if (lat != 11) begin errors++; $display("FAIL midreset_restart_latency: got %0d expected 11", lat); end
    for (int r = 0; r < 11; r++) begin
      rd(r, v);
      checks++; if (v !== exp_ks[r]) begin errors++; $display("FAIL midreset_rk%0d_after: got %h expected %h", r, v, exp_ks[r]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, kb, v;
    int lat, bn;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    model_expand(ka);
    for (int r = 0; r < 11; r++) a_ks[r] = exp_ks[r];
    model_expand(kb);
    bus.key = ka; bus.start = 1'b1;
    step();
    wait_done(lat, bn);
    checks++; if (lat != 11) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 11", lat); end
    bus.key = kb;
    step();
    checks++; if (bus.key_valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: got kv=%b busy=%b done=%b expected 0 1 0", bus.key_valid, bus.busy, bus.done); end
    bus.start = 1'b0;
    bus.rd_idx = 4'd3;
    repeat (3) step();
    checks++; if (bus.rd_key !== a_ks[3]) begin errors++; $display("FAIL b2b_same_slot_old: got %h expected %h", bus.rd_key, a_ks[3]); end
    step();
    checks++; if (bus.rd_key !== exp_ks[3]) begin errors++; $display("FAIL b2b_same_slot_new: got %h expected %h", bus.rd_key, exp_ks[3]); end
    wait_done(lat, bn);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", bus.done); end
    for (int r = 0; r < 11; r++) begin
      rd(r, v);
      checks++; if (v !== exp_ks[r]) begin errors++; $display("FAIL b2b_rk%0d: got %h expected %h", r, v, exp_ks[r]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [127:0] v;
    for (int r = 11; r < 16; r++) begin
      rd(r, v);
      checks++; if (v !== '0) begin errors++; $display("FAIL oob_rd%0d: got %h expected 0", r, v); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.key = '0; bus.rd_idx = 4'd0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
